mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 38 +++
 rtl/mem_port_arbiter_if.sv | 24 ++
 rtl/mem_arb_timer.sv | 29 ++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_e     : bus-side FSM state
//   owner_e         : which pipeline port owns the current access
//   bus_cmd_t       : command latched when an access is started
//   TIMEOUT_CYC_DEF : default ADDR+WAIT cycle budget before abort
//   pick_owner()    : arbitration rule for the IDLE state
package mem_arb_pkg;

  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_cmd_t;

  // A tie goes to whichever side did not complete the previous access.
  function automatic owner_e pick_owner(input logic if_r, input logic mem_r,
                                        input owner_e last);
    if (if_r && mem_r) return (last == OWN_IF) ? OWN_MEM : OWN_IF;
    else if (mem_r)    return OWN_MEM;
    else               return OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Shared memory port between the arbiter (master) and memory (slave).
//   bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb : command, held until bus_gnt
//   bus_gnt    : memory accepts the command this cycle
//   bus_rvalid : completion for reads and writes, bus_rdata valid with it
interface mem_port_arbiter_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_arb_timer.sv
// Access watchdog: clear/enable counter that flags the LIMIT-th enabled cycle.
//   clr    : restart from zero (access start)
//   en     : count this cycle (access in ADDR or WAIT)
//   expire : this enabled cycle is the LIMIT-th since clr
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CW'(1);
  end

  // cnt counts cycles already spent, so LIMIT-1 marks the last allowed one.
  assign expire = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and the MEM load/store port onto one memory
// bus, one access at a time (IDLE -> ADDR -> WAIT -> RESP).
//   clk, rst_n        : clock, async active-low reset
//   if_req/if_addr    : fetch request, held until if_valid
//   if_flush          : drop the result of an in-flight fetch
//   mem_req/mem_*     : load/store request, held until mem_valid
//   halt              : no new access may start
//   bus               : shared memory port (master side)
//   if_valid/if_rdata : fetch done pulse + instruction
//   mem_valid/mem_rdata : MEM done pulse + load data
//   if_stall/mem_stall: stall requests to pipeline control
//   bus_err           : one-cycle pulse when an access times out
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        halt,
  mem_port_arbiter_if.master bus,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_rdata,
  output logic        if_stall,
  output logic        mem_stall,
  output logic        bus_err
);

  arb_state_e state, state_nxt;
  owner_e     owner, last_owner, pick;
  bus_cmd_t   cmd;
  logic       discard;
  logic       start, done, abort, expire, timer_clr, timer_en;

  assign start     = !halt && (if_req || mem_req);
  assign pick      = pick_owner(if_req, mem_req, last_owner);
  assign done      = (state == ST_WAIT) && bus.bus_rvalid;
  assign timer_clr = (state == ST_IDLE) && start;
  assign timer_en  = (state == ST_ADDR) || (state == ST_WAIT);
  // Progress in the final allowed cycle wins over the timeout.
  assign abort     = expire && (((state == ST_ADDR) && !bus.bus_gnt) ||
                                ((state == ST_WAIT) && !bus.bus_rvalid));

  mem_arb_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (expire)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_ADDR;
      ST_ADDR: if (bus.bus_gnt) state_nxt = ST_WAIT;
               else if (abort)  state_nxt = ST_IDLE;
      ST_WAIT: if (bus.bus_rvalid) state_nxt = ST_RESP;
               else if (abort)     state_nxt = ST_IDLE;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs: command is only presented while in ADDR.
  always_comb begin
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = 32'h0;
    bus.bus_wdata = 32'h0;
    bus.bus_wstrb = 4'h0;
    if (state == ST_ADDR) begin
      bus.bus_req   = 1'b1;
      bus.bus_we    = cmd.we;
      bus.bus_addr  = cmd.addr;
      bus.bus_wdata = cmd.wdata;
      bus.bus_wstrb = cmd.wstrb;
    end
  end

  // Datapath: command latch, owner tracking, response capture, pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_IF;
      last_owner <= OWN_IF;
      cmd        <= '0;
      discard    <= 1'b0;
      if_valid   <= 1'b0;
      if_rdata   <= 32'h0;
      mem_valid  <= 1'b0;
      mem_rdata  <= 32'h0;
      bus_err    <= 1'b0;
    end else begin
      // A flush in the completion cycle also kills the fetch result.
      if_valid  <= done && (owner == OWN_IF) && !discard && !if_flush;
      mem_valid <= done && (owner == OWN_MEM);
      bus_err   <= abort;

      if (timer_clr) begin
        owner <= pick;
        if (pick == OWN_MEM)
          cmd <= '{we: mem_we, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
        else
          cmd <= '{we: 1'b0, addr: if_addr, wdata: 32'h0, wstrb: 4'h0};
      end

      if (done) begin
        last_owner <= owner;
        if (owner == OWN_MEM)
          mem_rdata <= bus.bus_rdata;
        else if (!discard && !if_flush)
          if_rdata <= bus.bus_rdata;
      end

      if (state_nxt == ST_IDLE)
        discard <= 1'b0;
      else if (if_flush && (owner == OWN_IF) && timer_en)
        discard <= 1'b1;
    end
  end

  assign if_stall  = if_req  & ~if_valid;
  assign mem_stall = mem_req & ~mem_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int TO = 64;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, mem_req = 1'b0, mem_we = 1'b0, halt = 1'b0;
  logic [31:0] if_addr = 32'h0, mem_addr = 32'h0, mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        if_valid, mem_valid, if_stall, mem_stall, bus_err;
  logic [31:0] if_rdata, mem_rdata;
  int          n_vec = 0, n_err = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .halt(halt),
    .bus(bus),
    .if_valid(if_valid), .if_rdata(if_rdata), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .if_stall(if_stall), .mem_stall(mem_stall),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    if_req = 1'b0; if_flush = 1'b0; mem_req = 1'b0; mem_we = 1'b0; halt = 1'b0;
    if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'h0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [139:0] outs;
    apply_reset();
    rst_n = 1'b0; #1;
    outs = {bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_wdata, bus.bus_wstrb,
            if_valid, if_rdata, mem_valid, mem_rdata, if_stall, mem_stall, bus_err};
    n_vec++; if (outs !== '0) begin n_err++; $display("FAIL reset_outs: got %h want 0", outs); end
    step(); rst_n = 1'b1; step();
    outs = {bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_wdata, bus.bus_wstrb,
            if_valid, if_rdata, mem_valid, mem_rdata, if_stall, mem_stall, bus_err};
    n_vec++; if (outs !== '0) begin n_err++; $display("FAIL reset_release_outs: got %h want 0", outs); end
  endtask

  task automatic test_fetch_latency();
    apply_reset();
    if_req = 1'b1; if_addr = 32'h100; step();
    n_vec++; if ({bus.bus_req, bus.bus_we, bus.bus_addr} !== {2'b10, 32'h100}) begin
      n_err++; $display("FAIL fetch_cmd: got req/we/addr %b/%b/%h want 1/0/100", bus.bus_req, bus.bus_we, bus.bus_addr); end
    n_vec++; if (if_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall_pending: got %b want 1", if_stall); end
    bus.bus_gnt = 1'b1; step();
    n_vec++; if (bus.bus_req !== 1'b0) begin n_err++; $display("FAIL fetch_wait_req: got %b want 0", bus.bus_req); end
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h13; step();
    n_vec++; if ({if_valid, if_rdata, if_stall} !== {1'b1, 32'h13, 1'b0}) begin
      n_err++; $display("FAIL fetch_resp: got valid/data/stall %b/%h/%b want 1/00000013/0", if_valid, if_rdata, if_stall); end
    bus.bus_rvalid = 1'b0; if_req = 1'b0; step();
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL fetch_pulse_len: got %b want 0", if_valid); end
  endtask

  task automatic test_tie();
    apply_reset();
    if_req = 1'b1; if_addr = 32'h300;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF; mem_wstrb = 4'hF;
    step();
    n_vec++; if ({bus.bus_we, bus.bus_addr, bus.bus_wdata, bus.bus_wstrb} !== {1'b1, 32'h2000, 32'hDEADBEEF, 4'hF}) begin
      n_err++; $display("FAIL tie_first_mem: got we/addr/wdata/strb %b/%h/%h/%h want 1/2000/deadbeef/f",
                        bus.bus_we, bus.bus_addr, bus.bus_wdata, bus.bus_wstrb); end
    bus.bus_gnt = 1'b1; step();
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b1; step();
    n_vec++; if ({mem_valid, if_valid} !== 2'b10) begin n_err++; $display("FAIL tie_mem_done: got mem/if valid %b%b want 10", mem_valid, if_valid); end
    bus.bus_rvalid = 1'b0; mem_req = 1'b0; step(); step();
    n_vec++; if ({bus.bus_req, bus.bus_we, bus.bus_addr} !== {2'b10, 32'h300}) begin
      n_err++; $display("FAIL tie_then_if: got req/we/addr %b/%b/%h want 1/0/300", bus.bus_req, bus.bus_we, bus.bus_addr); end
    bus.bus_gnt = 1'b1; step();
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hAA; step();
    n_vec++; if ({if_valid, if_rdata} !== {1'b1, 32'hAA}) begin n_err++; $display("FAIL tie_if_done: got %b/%h want 1/aa", if_valid, if_rdata); end
    bus.bus_rvalid = 1'b0; if_addr = 32'h304; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2004;
    step(); step();
    n_vec++; if ({bus.bus_req, bus.bus_addr} !== {1'b1, 32'h2004}) begin
      n_err++; $display("FAIL tie_second_mem: got req/addr %b/%h want 1/2004", bus.bus_req, bus.bus_addr); end
  endtask

  task automatic test_flush();
    apply_reset();
    if_req = 1'b1; if_addr = 32'h104; step();
    bus.bus_gnt = 1'b1; step();
    bus.bus_gnt = 1'b0; if_flush = 1'b1; if_addr = 32'h200; step();
    if_flush = 1'b0; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h55; step();
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_valid: got %b want 0", if_valid); end
    bus.bus_rvalid = 1'b0; step();
    n_vec++; if ({if_valid, bus.bus_req} !== 2'b00) begin n_err++; $display("FAIL flush_idle: got valid/req %b%b want 00", if_valid, bus.bus_req); end
    step();
    n_vec++; if ({bus.bus_req, bus.bus_addr} !== {1'b1, 32'h200}) begin
      n_err++; $display("FAIL flush_refetch: got req/addr %b/%h want 1/200", bus.bus_req, bus.bus_addr); end
    bus.bus_gnt = 1'b1; step();
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h77; step();
    n_vec++; if ({if_valid, if_rdata} !== {1'b1, 32'h77}) begin n_err++; $display("FAIL flush_cleared: got %b/%h want 1/77", if_valid, if_rdata); end
    bus.bus_rvalid = 1'b0; if_req = 1'b0;
  endtask

  task automatic test_timeout();
    int hi = 0;
    int guard = 0;
    logic seen_valid = 1'b0;
    apply_reset();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h4000; step();
    // stray completions while in ADDR must be ignored
    while (bus.bus_req === 1'b1 && bus_err !== 1'b1 && guard < 200) begin
      hi++; guard++;
      bus.bus_rvalid = 1'($urandom & 1);
      step();
      if (mem_valid === 1'b1) seen_valid = 1'b1;
    end
    bus.bus_rvalid = 1'b0;
    n_vec++; if (hi != TO) begin n_err++; $display("FAIL timeout_addr_cycles: got %0d want %0d", hi, TO); end
    n_vec++; if ({bus_err, bus.bus_req, seen_valid} !== 3'b100) begin
      n_err++; $display("FAIL timeout_err: got err/req/valid %b%b%b want 100", bus_err, bus.bus_req, seen_valid); end
    step();
    n_vec++; if ({bus_err, bus.bus_req, bus.bus_addr} !== {2'b01, 32'h4000}) begin
      n_err++; $display("FAIL timeout_reissue: got err/req/addr %b/%b/%h want 0/1/4000", bus_err, bus.bus_req, bus.bus_addr); end
  endtask

  task automatic test_halt();
    logic any_req = 1'b0;
    apply_reset();
    if_req = 1'b1; if_addr = 32'h500; step();
    bus.bus_gnt = 1'b1; step();
    bus.bus_gnt = 1'b0; halt = 1'b1; mem_req = 1'b1; mem_addr = 32'h600; step();
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h99; step();
    n_vec++; if ({if_valid, if_rdata} !== {1'b1, 32'h99}) begin n_err++; $display("FAIL halt_complete: got %b/%h want 1/99", if_valid, if_rdata); end
    bus.bus_rvalid = 1'b0; if_req = 1'b0; step();
    for (int i = 0; i < 5; i++) begin
      if (bus.bus_req !== 1'b0) any_req = 1'b1;
      step();
    end
    n_vec++; if (any_req !== 1'b0) begin n_err++; $display("FAIL halt_blocks: got bus_req seen %b want 0", any_req); end
    halt = 1'b0; step();
    n_vec++; if ({bus.bus_req, bus.bus_addr} !== {1'b1, 32'h600}) begin
      n_err++; $display("FAIL halt_release: got req/addr %b/%h want 1/600", bus.bus_req, bus.bus_addr); end
  endtask

  task automatic test_reset_mid();
    logic spur = 1'b0;
    apply_reset();
    if_req = 1'b1; if_addr = 32'h700; step();
    bus.bus_gnt = 1'b1; step();
    bus.bus_gnt = 1'b0; if_req = 1'b0; rst_n = 1'b0; #1;
    n_vec++; if ({bus.bus_req, if_valid, mem_valid, bus_err, if_stall, if_rdata} !== '0) begin
      n_err++; $display("FAIL rstmid_outs: got req/ifv/memv/err/stall %b%b%b%b%b want 00000",
                        bus.bus_req, if_valid, mem_valid, bus_err, if_stall); end
    step(); rst_n = 1'b1; step();
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hBAD; step();
    bus.bus_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ({if_valid, mem_valid, bus_err, bus.bus_req} !== 4'b0) spur = 1'b1;
      step();
    end
    n_vec++; if (spur !== 1'b0) begin n_err++; $display("FAIL rstmid_late_rvalid: got activity %b want 0", spur); end
  endtask

  // Random traffic against a transaction-level model: who wins, what is put
  // on the bus, and who gets which data back.
  task automatic test_random(input int iters);
    logic last_mem = 1'b0;
    logic win_mem, exp_we;
    logic [31:0] exp_addr, d;
    int gd, rd;
    apply_reset();
    for (int it = 0; it < iters; it++) begin
      if (!if_req && ($urandom_range(0, 2) != 0)) begin if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC; end
      if (!mem_req && ($urandom_range(0, 2) != 0)) begin
        mem_req = 1'b1; mem_we = 1'($urandom & 1); mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
      end
      if (!if_req && !mem_req) begin if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC; end
      if_flush = 1'($urandom & 1);
      win_mem  = (if_req && mem_req) ? !last_mem : mem_req;
      exp_addr = win_mem ? mem_addr : if_addr;
      exp_we   = win_mem ? mem_we : 1'b0;
      step();
      if_flush = 1'b0;
      n_vec++; if ({bus.bus_req, bus.bus_we, bus.bus_addr} !== {1'b1, exp_we, exp_addr}) begin
        n_err++; $display("FAIL rnd_cmd[%0d]: got req/we/addr %b/%b/%h want 1/%b/%h", it, bus.bus_req, bus.bus_we, bus.bus_addr, exp_we, exp_addr); end
      if (win_mem) begin
        n_vec++; if ({bus.bus_wdata, bus.bus_wstrb} !== {mem_wdata, mem_wstrb}) begin
          n_err++; $display("FAIL rnd_wdata[%0d]: got %h/%h want %h/%h", it, bus.bus_wdata, bus.bus_wstrb, mem_wdata, mem_wstrb); end
      end
      gd = $urandom_range(0, 3);
      for (int g = 0; g < gd; g++) begin
        bus.bus_rvalid = 1'($urandom & 1);
        step();
        n_vec++; if ({bus.bus_req, bus.bus_addr} !== {1'b1, exp_addr}) begin
          n_err++; $display("FAIL rnd_hold[%0d]: got req/addr %b/%h want 1/%h", it, bus.bus_req, bus.bus_addr, exp_addr); end
      end
      bus.bus_rvalid = 1'b0; bus.bus_gnt = 1'b1; step();
      n_vec++; if (bus.bus_req !== 1'b0) begin n_err++; $display("FAIL rnd_wait_req[%0d]: got %b want 0", it, bus.bus_req); end
      rd = $urandom_range(0, 3);
      for (int r = 0; r < rd; r++) begin
        bus.bus_gnt = 1'($urandom & 1);
        step();
        n_vec++; if ({if_valid, mem_valid} !== 2'b00) begin
          n_err++; $display("FAIL rnd_early_valid[%0d]: got %b%b want 00", it, if_valid, mem_valid); end
      end
      d = $urandom;
      bus.bus_gnt = 1'($urandom & 1); bus.bus_rvalid = 1'b1; bus.bus_rdata = d; step();
      bus.bus_rvalid = 1'b0; bus.bus_gnt = 1'b0;
      n_vec++; if ({if_valid, mem_valid} !== {!win_mem, win_mem}) begin
        n_err++; $display("FAIL rnd_valid[%0d]: got if/mem %b%b want %b%b", it, if_valid, mem_valid, !win_mem, win_mem); end
      n_vec++; if ({if_stall, mem_stall} !== {win_mem ? if_req : 1'b0, win_mem ? 1'b0 : mem_req}) begin
        n_err++; $display("FAIL rnd_stall[%0d]: got if/mem %b%b", it, if_stall, mem_stall); end
      if (!win_mem || !exp_we) begin
        n_vec++; if ((win_mem ? mem_rdata : if_rdata) !== d) begin
          n_err++; $display("FAIL rnd_rdata[%0d]: got %h want %h", it, win_mem ? mem_rdata : if_rdata, d); end
      end
      last_mem = win_mem;
      if (win_mem) mem_req = 1'b0; else if_req = 1'b0;
      if_flush = 1'($urandom & 1);
      step();
      if_flush = 1'b0;
      n_vec++; if ({if_valid, mem_valid, bus.bus_req} !== 3'b000) begin
        n_err++; $display("FAIL rnd_idle[%0d]: got ifv/memv/req %b%b%b want 000", it, if_valid, mem_valid, bus.bus_req); end
    end
  endtask

  initial begin
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'h0;
    test_reset();
    test_fetch_latency();
    test_tie();
    test_flush();
    test_timeout();
    test_halt();
    test_reset_mid();
    test_random(40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
